// File: rtl/program_loader.sv
// program_loader: writes a valid/data word stream into instruction memory, tracks count and XOR checksum,
// and releases the CPU with a single start pulse when the stream ends cleanly.
module program_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic [15:0]       checksum,
  output logic              load_done,
  output logic              cpu_start,
  output logic              overflow_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);
  state_t state;
  logic   full;
  logic   accept;
  assign full   = word_count == MAX_CNT;
  assign accept = in_valid && (state == IDLE || (state == LOAD && !full));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      word_count   <= '0;
      checksum     <= '0;
      load_done    <= 1'b0;
      cpu_start    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      mem_we    <= accept;
      cpu_start <= 1'b0;
      if (accept) begin
        mem_addr   <= BASE_ADDR + word_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        word_count <= word_count + 1'b1;
        checksum   <= checksum ^ in_data;
      end
      if (state == IDLE && in_valid)
        state <= LOAD;
      if (state == LOAD && in_valid && full) begin
        state        <= ERROR;
        overflow_err <= 1'b1;
      end
      if (state == LOAD && !in_valid) begin
        state     <= DONE;
        load_done <= 1'b1;
        cpu_start <= 1'b1;
      end
    end
  end
endmodule
